// File: rtl/sap_1_controller_sequencer_if.sv
// sap_1_controller_sequencer_if: run/step/opcode inputs and ring/control-word outputs of the SAP-1 controller
interface sap_1_controller_sequencer_if;
    logic        run;
    logic        step;
    logic [3:0]  opcode;
    logic [5:0]  t;
    logic [11:0] con;
    logic        adv;
    logic        instr_done;
    logic        halted;
    logic        illegal;
    modport master (output run, step, opcode, input t, con, adv, instr_done, halted, illegal);
    modport slave  (input run, step, opcode, output t, con, adv, instr_done, halted, illegal);
endinterface

// File: rtl/sap_1_controller_sequencer.sv
// sap_1_controller_sequencer: SAP-1 six-state ring counter, opcode decoder and control-word generator
module sap_1_controller_sequencer (
    input  logic                                clk_i,
    input  logic                                clr_i,
    sap_1_controller_sequencer_if.slave         bus
);
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
    localparam logic [11:0] CON_IDLE = 12'h3E3;
    logic [5:0]  t_q, t_d;
    logic        step_q, halted_q, halted_d, illegal_q, illegal_d;
    logic        adv, is_lda, is_add, is_sub, is_out, is_hlt, at_t4;
    logic [11:0] con;
    assign is_lda = bus.opcode == OP_LDA;
    assign is_add = bus.opcode == OP_ADD;
    assign is_sub = bus.opcode == OP_SUB;
    assign is_out = bus.opcode == OP_OUT;
    assign is_hlt = bus.opcode == OP_HLT;
    assign adv    = ~halted_q & (bus.run | (bus.step & ~step_q));
    assign at_t4  = adv & (t_q == T4);
    // HLT stops the ring at the T4 edge; any other opcode keeps rotating
    always_comb begin
        t_d       = adv ? {t_q[4:0], t_q[5]} : t_q;
        halted_d  = halted_q;
        illegal_d = illegal_q | (at_t4 & ~(is_lda | is_add | is_sub | is_out | is_hlt));
        if (at_t4 && is_hlt) begin
            t_d      = 6'b0;
            halted_d = 1'b1;
        end
    end
    always_comb begin
        con = CON_IDLE;
        if (adv) begin
            case (t_q)
                T1:      con = 12'h5E3;
                T2:      con = 12'hBE3;
                T3:      con = 12'h263;
                T4:      con = (is_lda | is_add | is_sub) ? 12'h1A3 : is_out ? 12'h3F2 : CON_IDLE;
                T5:      con = is_lda ? 12'h2C3 : (is_add | is_sub) ? 12'h2E1 : CON_IDLE;
                T6:      con = is_add ? 12'h3C7 : is_sub ? 12'h3CF : CON_IDLE;
                default: con = CON_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            t_q       <= T1;
            step_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            t_q       <= t_d;
            step_q    <= bus.step;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end
    assign bus.t          = t_q;
    assign bus.con        = con;
    assign bus.adv        = adv;
    assign bus.instr_done = adv & (t_q == T6);
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// tb_sap_1_controller_sequencer: vector table plus hand sequences, checked through an expected-output queue
module tb_sap_1_controller_sequencer;
    typedef struct {
        logic        clr, run, step;
        logic [3:0]  op;
        logic [5:0]  t;
        logic [11:0] con;
        logic        adv, done, halted, illegal;
    } vec_t;
    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   failures = 0;
    int   idx = 0;
    vec_t vecs[$];
    logic [21:0] sb[$];
    sap_1_controller_sequencer_if bus ();
    sap_1_controller_sequencer dut (.clk_i(clk), .clr_i(clr), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic c, r, s, input logic [3:0] op, input logic [5:0] t,
                                input logic [11:0] con, input logic adv, done, halted, illegal);
        vec_t v;
        v.clr = c; v.run = r; v.step = s; v.op = op; v.t = t; v.con = con;
        v.adv = adv; v.done = done; v.halted = halted; v.illegal = illegal;
        return v;
    endfunction
    task automatic add_instr(input logic [3:0] op, input logic [11:0] c4, c5, c6, input logic ill);
        vecs.push_back(mk(0, 1, 0, op, 6'h01, 12'h5E3, 1, 0, 0, ill));
        vecs.push_back(mk(0, 1, 0, op, 6'h02, 12'hBE3, 1, 0, 0, ill));
        vecs.push_back(mk(0, 1, 0, op, 6'h04, 12'h263, 1, 0, 0, ill));
        vecs.push_back(mk(0, 1, 0, op, 6'h08, c4, 1, 0, 0, ill));
        vecs.push_back(mk(0, 1, 0, op, 6'h10, c5, 1, 0, 0, ill));
        vecs.push_back(mk(0, 1, 0, op, 6'h20, c6, 1, 1, 0, ill));
    endtask
    task automatic apply(input vec_t v);
        logic [21:0] exp_o, got;
        @(negedge clk);
        clr = v.clr; bus.run = v.run; bus.step = v.step; bus.opcode = v.op;
        sb.push_back({v.t, v.con, v.adv, v.done, v.halted, v.illegal});
        #1;
        exp_o = sb.pop_front();
        got = {bus.t, bus.con, bus.adv, bus.instr_done, bus.halted, bus.illegal};
        checks++;
        if (got !== exp_o) begin
            failures++;
            $display("FAIL vec%0d: got t=%h con=%h adv/done/halt/ill=%b required t=%h con=%h adv/done/halt/ill=%b",
                     idx, got[21:16], got[15:4], got[3:0], exp_o[21:16], exp_o[15:4], exp_o[3:0]);
        end
        idx++;
    endtask
    initial begin
        clr = 1'b1; bus.run = 1'b0; bus.step = 1'b0; bus.opcode = 4'h0;
        vecs.push_back(mk(1, 0, 0, 4'h0, 6'h01, 12'h3E3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 6'h01, 12'h3E3, 0, 0, 0, 0));
        add_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3, 0);
        add_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7, 0);
        add_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF, 0);
        add_instr(4'hE, 12'h3F2, 12'h3E3, 12'h3E3, 0);
        vecs.push_back(mk(0, 0, 1, 4'h0, 6'h01, 12'h5E3, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 4'h0, 6'h02, 12'h3E3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 6'h02, 12'h3E3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h0, 6'h02, 12'hBE3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 6'h04, 12'h3E3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h5, 6'h04, 12'h263, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h5, 6'h08, 12'h3E3, 1, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        foreach (vecs[i]) apply(vecs[i]);
        // CLR lands in T5 of the illegal instruction
        apply(mk(1, 1, 0, 4'h5, 6'h10, 12'h3E3, 1, 0, 0, 1));
        apply(mk(0, 0, 0, 4'h5, 6'h01, 12'h3E3, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 4'hF, 6'h01, 12'h5E3, 1, 0, 0, 0));
        apply(mk(0, 1, 0, 4'hF, 6'h02, 12'hBE3, 1, 0, 0, 0));
        apply(mk(0, 1, 0, 4'hF, 6'h04, 12'h263, 1, 0, 0, 0));
        apply(mk(0, 1, 0, 4'hF, 6'h08, 12'h3E3, 1, 0, 0, 0));
        for (int i = 0; i < 20; i++)
            apply(mk(0, 1'($urandom_range(0, 1)), 1'(i % 2), 4'($urandom_range(0, 15)), 6'h00, 12'h3E3, 0, 0, 1, 0));
        apply(mk(1, 1, 1, 4'h0, 6'h00, 12'h3E3, 0, 0, 1, 0));
        apply(mk(0, 0, 0, 4'h0, 6'h01, 12'h3E3, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 4'h0, 6'h01, 12'h5E3, 1, 0, 0, 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
